// File: rtl/display_scan_scheduler.sv
// Single-clock digit scanner for the shared 4-digit common-anode display.
// Optional timer blink while paused is compiled in with `define BLINK_EN.
module display_scan_scheduler #(
  parameter int DIV_SCAN     = 12500,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] placar_bcd,
  input  logic [7:0] cronometro_bcd,
  input  logic       pausa,
  output logic [3:0] anodo,
  output logic [3:0] bcd,
  output logic       frame_fim
);

  localparam int CW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam logic [CW-1:0] LAST_C  = CW'(DIV_SCAN - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [7:0]    plc_q, plc_d;
  logic [7:0]    crn_q, crn_d;
  logic          first_q, first_d;
  logic [3:0]    anodo_q, anodo_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          fim_q, fim_d;
  logic          frame_wrap;
  logic          hide_timer;
  logic [3:0]    pat;
  logic [3:0]    val;

`ifdef BLINK_EN
  localparam int FW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] LAST_F = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [FW-1:0] HALF_F = FW'(BLINK_FRAMES);
  logic [FW-1:0] fcnt_q, fcnt_d;
`else
  wire unused_pausa = pausa;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      slot_q  <= '0;
      plc_q   <= '0;
      crn_q   <= '0;
      first_q <= 1'b1;
      anodo_q <= 4'b1111;
      bcd_q   <= '0;
      fim_q   <= 1'b0;
`ifdef BLINK_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      plc_q   <= plc_d;
      crn_q   <= crn_d;
      first_q <= first_d;
      anodo_q <= anodo_d;
      bcd_q   <= bcd_d;
      fim_q   <= fim_d;
`ifdef BLINK_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  // Everything is decided from the post-edge position so the registered
  // outputs line up with the counter value they belong to.
  always_comb begin
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    plc_d      = plc_q;
    crn_d      = crn_q;
    first_d    = first_q;
    frame_wrap = enable && (cnt_q == LAST_C) && (slot_q == 2'd3);
    if (enable) begin
      if (cnt_q == LAST_C) begin
        cnt_d  = '0;
        slot_d = slot_q + 2'd1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
      if (frame_wrap || first_q) begin
        plc_d   = placar_bcd;
        crn_d   = cronometro_bcd;
        first_d = 1'b0;
      end
    end

`ifdef BLINK_EN
    fcnt_d = fcnt_q;
    if (frame_wrap) fcnt_d = (fcnt_q == LAST_F) ? '0 : fcnt_q + FW'(1);
    hide_timer = pausa && (fcnt_d >= HALF_F) && slot_d[1];
`else
    hide_timer = 1'b0;
`endif

    pat = 4'b1111;
    val = 4'd0;
    case (slot_d)
      2'd0: begin pat = 4'b1110; val = plc_d[3:0]; end
      2'd1: begin pat = 4'b1101; val = plc_d[7:4]; end
      2'd2: begin pat = 4'b1011; val = crn_d[3:0]; end
      default: begin pat = 4'b0111; val = crn_d[7:4]; end
    endcase

    if (!enable)                              state_d = ST_OFF;
    else if ((cnt_d < BLANK_C) || hide_timer) state_d = ST_BLANK;
    else                                      state_d = ST_SHOW;

    anodo_d = (state_d == ST_SHOW) ? pat : 4'b1111;
    // bcd keeps tracking the slot during blanking so the decoder settles early
    bcd_d   = enable ? val : bcd_q;
    fim_d   = frame_wrap;
  end

  assign anodo     = anodo_q;
  assign bcd       = bcd_q;
  assign frame_fim = fim_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler (DIV_SCAN=8, BLANK_CYCLES=2, BLINK_FRAMES=2).
module tb_display_scan_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] placar_bcd;
  logic [7:0] cronometro_bcd;
  logic       pausa;
  logic [3:0] anodo;
  logic [3:0] bcd;
  logic       frame_fim;

  int n_chk  = 0;
  int n_fail = 0;

  // expected scan position and snapshot, tracked by the bench
  logic [2:0] e_cnt;
  logic [1:0] e_slot;
  logic [7:0] s_plc, s_crn;
  int         e_frm;

  display_scan_scheduler #(.DIV_SCAN(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .placar_bcd(placar_bcd), .cronometro_bcd(cronometro_bcd), .pausa(pausa),
    .anodo(anodo), .bcd(bcd), .frame_fim(frame_fim)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] pat_of(input logic [1:0] s);
    case (s)
      2'd0: pat_of = 4'b1110;
      2'd1: pat_of = 4'b1101;
      2'd2: pat_of = 4'b1011;
      default: pat_of = 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] dig_of(input logic [1:0] s, input logic [7:0] p, input logic [7:0] c);
    case (s)
      2'd0: dig_of = p[3:0];
      2'd1: dig_of = p[7:4];
      2'd2: dig_of = c[3:0];
      default: dig_of = c[7:4];
    endcase
  endfunction

  task automatic restart_pos();
    e_cnt  = '0;
    e_slot = '0;
    e_frm  = 0;
    s_plc  = placar_bcd;
    s_crn  = cronometro_bcd;
  endtask

  // enabled cycles: advance expected position then compare all outputs
  task automatic run(input string tag, input int n);
    logic       fim_e;
    logic       hide;
    logic [3:0] an_e;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      fim_e = (e_slot == 2'd3) && (e_cnt == 3'd7);
      if (e_cnt == 3'd7) begin
        e_cnt  = '0;
        e_slot = e_slot + 2'd1;
      end else begin
        e_cnt = e_cnt + 3'd1;
      end
      if (fim_e) begin
        s_plc = placar_bcd;
        s_crn = cronometro_bcd;
        e_frm = (e_frm + 1) % 4;
      end
      hide = 1'b0;
`ifdef BLINK_EN
      hide = pausa && (e_frm >= 2) && e_slot[1];
`endif
      an_e = ((e_cnt < 3'd2) || hide) ? 4'b1111 : pat_of(e_slot);
      chk($sformatf("%s anodo s%0d c%0d", tag, e_slot, e_cnt), 32'(anodo), 32'(an_e));
      chk($sformatf("%s bcd s%0d c%0d", tag, e_slot, e_cnt), 32'(bcd), 32'(dig_of(e_slot, s_plc, s_crn)));
      chk($sformatf("%s frame_fim s%0d c%0d", tag, e_slot, e_cnt), 32'(frame_fim), 32'(fim_e));
    end
  endtask

  // disabled cycles: position frozen, display dark, bcd held
  task automatic run_off(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      chk({tag, " anodo"}, 32'(anodo), 32'hF);
      chk({tag, " bcd"}, 32'(bcd), 32'(dig_of(e_slot, s_plc, s_crn)));
      chk({tag, " frame_fim"}, 32'(frame_fim), 32'd0);
    end
  endtask

  task automatic run_rst(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      chk({tag, " anodo"}, 32'(anodo), 32'hF);
      chk({tag, " bcd"}, 32'(bcd), 32'd0);
      chk({tag, " frame_fim"}, 32'(frame_fim), 32'd0);
    end
  endtask

  initial begin
    reset          = 1'b0;
    enable         = 1'b0;
    placar_bcd     = 8'h42;
    cronometro_bcd = 8'h59;
    pausa          = 1'b0;

    run_rst("reset", 3);

    // basic scan, two full frames
    reset  = 1'b1;
    enable = 1'b1;
    restart_pos();
    run("scan", 64);

    // mid-frame input change must wait for the next frame
    run("pre_chg", 10);
    placar_bcd = 8'h77;
    run("mid_chg", 22);
    run("new_frame", 32);

    // freeze at slot2 cnt5
    run("to_freeze", 21);
    chk("freeze pos slot", 32'(e_slot), 32'd2);
    chk("freeze pos cnt", 32'(e_cnt), 32'd5);
    enable = 1'b0;
    run_off("frozen", 10);
    enable = 1'b1;
    run("resume", 7);

    // reset at slot3 cnt4, with new inputs including non-decimal digits
    chk("rst pos slot", 32'(e_slot), 32'd3);
    chk("rst pos cnt", 32'(e_cnt), 32'd4);
    placar_bcd     = 8'h13;
    cronometro_bcd = 8'hF6;
    reset = 1'b0;
    run_rst("mid_reset", 1);
    reset = 1'b1;
    restart_pos();
    run("after_reset", 40);

    // pausa only matters when blink is compiled in
    reset = 1'b0;
    pausa = 1'b1;
    run_rst("blink_reset", 1);
    reset = 1'b1;
    restart_pos();
    run("pausa", 4 * 32);
    pausa = 1'b0;
    run("unpaused", 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
